// File: rtl/jk_ff_pkg.sv
// Shared types for the JK/SR/D/T flip-flop bank.
// Mode encoding is visible on the bank's mode port, so the values are fixed.
package jk_ff_pkg;

    typedef enum logic [1:0] {
        MODE_JK = 2'd0,
        MODE_SR = 2'd1,
        MODE_D  = 2'd2,
        MODE_T  = 2'd3
    } ff_mode_t;

    localparam int MAX_WIDTH = 32;

endpackage

// File: rtl/jk_ff_next.sv
// Per-bit next-state logic for one flip-flop channel in the selected mode.
// Latency: combinational. Backpressure: none.
// Flags the forbidden SR input (S=R=1); the caller decides whether it counts.
module jk_ff_next
    import jk_ff_pkg::*;
(
    input  ff_mode_t mode,
    input  logic     j,
    input  logic     k,
    input  logic     q,
    output logic     q_next,
    output logic     sr_conflict
);

    always_comb begin
        q_next      = q;
        sr_conflict = 1'b0;
        case (mode)
            MODE_JK: begin
                case ({j, k})
                    2'b10:   q_next = 1'b1;
                    2'b01:   q_next = 1'b0;
                    2'b11:   q_next = ~q;
                    default: q_next = q;
                endcase
            end
            MODE_SR: begin
                case ({j, k})
                    2'b10:   q_next = 1'b1;
                    2'b01:   q_next = 1'b0;
                    2'b11: begin
                        q_next      = q;
                        sr_conflict = 1'b1;
                    end
                    default: q_next = q;
                endcase
            end
            MODE_D:  q_next = j;
            MODE_T:  q_next = q ^ j;
            default: q_next = q;
        endcase
    end

endmodule

// File: rtl/jk_ff_bank.sv
// Bank of WIDTH flip-flops sharing one run-time mode, with parallel load,
// sticky SR-conflict flags and a one-cycle changed mask. Latency: 1 clock to
// q/changed/conflict, qn combinational. Backpressure: none, sampled every edge.
module jk_ff_bank
    import jk_ff_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mode_we,
    input  logic [1:0]       mode_in,
    input  logic             en,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             conflict_clr,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn,
    output logic [1:0]       mode,
    output logic [WIDTH-1:0] changed,
    output logic [WIDTH-1:0] conflict
);

    ff_mode_t         mode_q, mode_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] changed_q, changed_d;
    logic [WIDTH-1:0] conflict_q, conflict_d;
    logic [WIDTH-1:0] bit_next, bit_conflict, new_conflict;

    // Every channel evaluates with the mode already registered, so a mode
    // write only takes effect from the edge after it.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        jk_ff_next u_next (
            .mode        (mode_q),
            .j           (j[i]),
            .k           (k[i]),
            .q           (q_q[i]),
            .q_next      (bit_next[i]),
            .sr_conflict (bit_conflict[i])
        );
    end

    always_comb begin
        mode_d       = mode_we ? ff_mode_t'(mode_in) : mode_q;
        new_conflict = '0;
        q_d          = q_q;
        if (load) begin
            q_d = load_data;
        end else if (en) begin
            q_d          = bit_next;
            new_conflict = bit_conflict;
        end
        changed_d  = q_d ^ q_q;
        // A fresh conflict beats a clear on the same edge.
        conflict_d = (conflict_q & ~{WIDTH{conflict_clr}}) | new_conflict;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q     <= MODE_JK;
            q_q        <= RESET_VAL;
            changed_q  <= '0;
            conflict_q <= '0;
        end else begin
            mode_q     <= mode_d;
            q_q        <= q_d;
            changed_q  <= changed_d;
            conflict_q <= conflict_d;
        end
    end

    assign q        = q_q;
    assign qn       = ~q_q;
    assign mode     = mode_q;
    assign changed  = changed_q;
    assign conflict = conflict_q;

endmodule
